// File: rtl/uart_mem_loader.sv
// UART-to-memory loader/dumper: captures LEN received bytes into memory, then streams them back out.
// Optional feature: define UART_MEM_LOADER_CHECKSUM_EN to append an additive checksum byte.
module uart_mem_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN    = 65536,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [7:0]        progress
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] LenC = CntW'(LEN);

`ifdef UART_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StLoad, StRd, StRdWait, StTxReq, StTxWait, StCsum, StDone
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StLoad, StRd, StRdWait, StTxReq, StTxWait, StDone
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d, count_inc;
  logic              seen_busy_q, seen_busy_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic              done_q, done_d;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign count_inc = count_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    seen_busy_d = seen_busy_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    done_d      = 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      StIdle: begin
        count_d = '0;
        if (start) begin
          state_d = StLoad;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLoad: begin
        // The final write lands in the cycle count hits LEN; the read starts one cycle later so
        // the single memory port never sees write and read together.
        if (count_q == LenC) begin
          count_d    = '0;
          state_d    = StRd;
          mem_re_d   = 1'b1;
          mem_addr_d = '0;
        end else if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = count_q[ADDR_W-1:0];
          mem_wdata_d = rx_data;
          count_d     = count_inc;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
          csum_d      = csum_q + rx_data;
`endif
        end
      end
      StRd:     state_d = StRdWait;
      StRdWait: begin
        tx_data_d = mem_rdata;
        state_d   = StTxReq;
      end
      StTxReq: begin
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          seen_busy_d = 1'b0;
          state_d     = StTxWait;
        end
      end
      StTxWait: begin
        if (tx_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
`ifdef UART_MEM_LOADER_CHECKSUM_EN
          // count already at LEN means the byte just sent was the checksum
          if (count_q == LenC) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            count_d = count_inc;
            if (count_inc == LenC) begin
              state_d = StCsum;
            end else begin
              state_d    = StRd;
              mem_re_d   = 1'b1;
              mem_addr_d = count_inc[ADDR_W-1:0];
            end
          end
`else
          count_d = count_inc;
          if (count_inc == LenC) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d    = StRd;
            mem_re_d   = 1'b1;
            mem_addr_d = count_inc[ADDR_W-1:0];
          end
`endif
        end
      end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      StCsum: begin
        tx_data_d = csum_q;
        state_d   = StTxReq;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      count_q     <= '0;
      seen_busy_q <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      done_q      <= 1'b0;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      seen_busy_q <= seen_busy_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      done_q      <= done_d;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign done      = done_q;
  assign busy      = (state_q != StIdle) && (state_q != StDone);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  assign checksum  = csum_q;
`endif

  if (CntW >= 8) begin : g_prog
    assign progress = count_q[7:0];
  end else begin : g_prog_ext
    assign progress = {{(8 - CntW){1'b0}}, count_q};
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench for uart_mem_loader (ADDR_W=4, LEN=16) with memory and transmitter models.
module tb_uart_mem_loader;
  localparam int unsigned AW     = 4;
  localparam int unsigned N      = 16;
  localparam int          Budget = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset, start, rx_valid, tx_start, mem_we, mem_re, busy, done;
  logic [7:0]    rx_data, tx_data, mem_wdata, progress;
  logic [AW-1:0] mem_addr;
  logic          tx_busy   = 1'b0;
  logic [7:0]    mem_rdata = 8'h00;
`ifdef UART_MEM_LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  uart_mem_loader #(.ADDR_W(AW), .LEN(N), .DATA_W(8)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .done     (done),
    .progress (progress)
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  // Environment: synchronous memory and a transmitter that stays busy busy_len cycles per byte.
  logic [7:0]    mem [N];
  logic [AW+7:0] wr_log [$];
  logic [7:0]    tx_log [$];
  int unsigned   busy_len  = 1;
  int unsigned   busy_left = 0;
  int unsigned   done_cnt  = 0;
  int unsigned   proto_err = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_log.push_back({mem_addr, mem_wdata});
    end
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (done) done_cnt <= done_cnt + 1;
    proto_err <= proto_err + ((mem_we && mem_re) ? 1 : 0) + ((tx_start && tx_busy) ? 1 : 0);
    if (tx_start) begin
      tx_log.push_back(tx_data);
      tx_busy   <= 1'b1;
      busy_left <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tx_busy   <= 1'b0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {tx_data, tx_start, mem_addr, mem_wdata, mem_we, mem_re, busy, done, progress};
  endfunction

  typedef struct {
    int          gap;
    int unsigned blen;
    bit          noise;
    int          mode;     // 0 random, 1 ascending, 2 F0/20 then zeros
    int unsigned exp_wr;
    int unsigned exp_done;
  } vec_t;

  logic [7:0] exp_bytes [N];

  task automatic run_case(input string tag, input vec_t v);
    int unsigned wbase, tbase, dbase, pbase;
    logic [7:0]  exp_tx [$];
    logic [7:0]  sum;
    bit          got;
    busy_len = v.blen;
    sum = 8'h00;
    for (int i = 0; i < N; i++) begin
      case (v.mode)
        1:       exp_bytes[i] = 8'(i);
        2:       exp_bytes[i] = (i == 0) ? 8'hF0 : (i == 1) ? 8'h20 : 8'h00;
        default: exp_bytes[i] = 8'($urandom_range(0, 255));
      endcase
      exp_tx.push_back(exp_bytes[i]);
      sum = sum + exp_bytes[i];
    end
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    exp_tx.push_back(sum);
`endif
    wbase = wr_log.size();
    tbase = tx_log.size();
    dbase = done_cnt;
    pbase = proto_err;

    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_busy"}, {63'd0, busy}, 64'd1);
    for (int i = 0; i < N; i++) begin
      rx_data  = exp_bytes[i];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      check($sformatf("%s_wr%0d", tag, i), {mem_we, mem_addr, mem_wdata},
            {1'b1, AW'(i), exp_bytes[i]});
      if (i != N - 1) repeat (v.gap) tick();
    end
    // Count has reached LEN; this extra byte must be dropped.
    check({tag, "_progress_len"}, {56'd0, progress}, 64'd16);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check({tag, "_rd0"}, {mem_we, mem_re, mem_addr}, {1'b0, 1'b1, AW'(0)});
    tick();
    tick();
    check({tag, "_txdata0"}, {56'd0, tx_data}, {56'd0, exp_bytes[0]});
    tick();
    check({tag, "_txstart0"}, {63'd0, tx_start}, 64'd1);

    got = 1'b0;
    for (int c = 0; c < Budget; c++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
      if (v.noise) begin
        start    = ($urandom_range(0, 7) == 0);
        rx_valid = ($urandom_range(0, 3) == 0);
        rx_data  = 8'($urandom);
      end
    end
    start    = 1'b0;
    rx_valid = 1'b0;
    check({tag, "_done_seen"}, {63'd0, got}, 64'd1);
    tick();
    check({tag, "_idle_after"}, {62'd0, busy, done}, 64'd0);
    repeat (3) tick();

    check({tag, "_n_writes"}, 64'(wr_log.size() - wbase), 64'(v.exp_wr));
    check({tag, "_n_done"}, 64'(done_cnt - dbase), 64'(v.exp_done));
    check({tag, "_proto"}, 64'(proto_err - pbase), 64'd0);
    check({tag, "_n_tx"}, 64'(tx_log.size() - tbase), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++) begin
      if (tbase + i < tx_log.size())
        check($sformatf("%s_tx%0d", tag, i), {56'd0, tx_log[tbase+i]}, {56'd0, exp_tx[i]});
    end
    for (int i = 0; i < N; i++)
      check($sformatf("%s_mem%0d", tag, i), {56'd0, mem[i]}, {56'd0, exp_bytes[i]});
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    check({tag, "_csum_hold"}, {56'd0, checksum}, {56'd0, sum});
`endif
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{gap: 20, blen: 3,  noise: 1'b0, mode: 1, exp_wr: N, exp_done: 1};
    vecs[1] = '{gap: 0,  blen: 1,  noise: 1'b0, mode: 0, exp_wr: N, exp_done: 1};
    vecs[2] = '{gap: 2,  blen: 50, noise: 1'b1, mode: 0, exp_wr: N, exp_done: 1};
    vecs[3] = '{gap: 1,  blen: 5,  noise: 1'b0, mode: 2, exp_wr: N, exp_done: 1};

    Reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    Reset = 1'b0;
    check("reset_outs", all_outs(), 64'd0);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    check("reset_csum", {56'd0, checksum}, 64'd0);
`endif
    // rx_valid in IDLE must not write
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    rx_valid = 1'b0;
    check("idle_rx_ignored", all_outs(), 64'd0);

    for (int k = 0; k < 4; k++) run_case($sformatf("v%0d", k), vecs[k]);

    // Reset after five loaded bytes, then a clean rerun from address 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_data  = 8'($urandom_range(0, 255));
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      tick();
    end
    check("midrun_progress", {56'd0, progress}, 64'd5);
    Reset = 1'b1;
    tick();
    check("midrun_reset_outs", all_outs(), 64'd0);
`ifdef UART_MEM_LOADER_CHECKSUM_EN
    check("midrun_reset_csum", {56'd0, checksum}, 64'd0);
`endif
    Reset = 1'b0;
    tick();
    run_case("after_reset", vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
